// File: rtl/wb_cmd_master.sv
// Wishbone classic initiator: turns a valid/ready command stream into single
// bus transactions and returns a response stream, with a bus timeout.
module wb_cmd_master #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_ni,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic                cmd_we_i,
  input  logic [ADDR_W-1:0]   cmd_adr_i,
  input  logic [DATA_W-1:0]   cmd_dat_i,
  input  logic [DATA_W/8-1:0] cmd_sel_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [DATA_W-1:0]   rsp_dat_o,
  output logic                rsp_err_o,
  output logic                wbm_cyc_o,
  output logic                wbm_stb_o,
  output logic                wbm_we_o,
  output logic [DATA_W/8-1:0] wbm_sel_o,
  output logic [ADDR_W-1:0]   wbm_adr_o,
  output logic [DATA_W-1:0]   wbm_dat_o,
  input  logic                wbm_ack_i,
  input  logic [DATA_W-1:0]   wbm_dat_i,
  output logic                busy_o
);

  localparam int unsigned SEL_W = DATA_W / 8;
  localparam bit          TO_EN = (TIMEOUT_CYCLES != 0);
  // Last counter value before abort; meaningless (and unused) when TO_EN is 0.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] to_cnt;

  // Single registered FSM; async reset drops cyc/stb at once and discards any transaction.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state       <= IDLE;
      to_cnt      <= '0;
      cmd_ready_o <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_dat_o   <= '0;
      rsp_err_o   <= 1'b0;
      wbm_cyc_o   <= 1'b0;
      wbm_stb_o   <= 1'b0;
      wbm_we_o    <= 1'b0;
      wbm_sel_o   <= SEL_W'(0);
      wbm_adr_o   <= '0;
      wbm_dat_o   <= '0;
      busy_o      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cmd_ready_o <= 1'b1;
          if (cmd_valid_i && cmd_ready_o) begin
            wbm_we_o    <= cmd_we_i;
            wbm_adr_o   <= cmd_adr_i;
            wbm_dat_o   <= cmd_dat_i;
            wbm_sel_o   <= cmd_sel_i;
            wbm_cyc_o   <= 1'b1;
            wbm_stb_o   <= 1'b1;
            to_cnt      <= '0;
            cmd_ready_o <= 1'b0;
            busy_o      <= 1'b1;
            state       <= BUS;
          end
        end

        BUS: begin
          // Ack takes precedence over a timeout firing on the same edge.
          if (wbm_ack_i) begin
            wbm_cyc_o   <= 1'b0;
            wbm_stb_o   <= 1'b0;
            rsp_dat_o   <= wbm_we_o ? '0 : wbm_dat_i;
            rsp_err_o   <= 1'b0;
            rsp_valid_o <= 1'b1;
            state       <= RESP;
          end else if (TO_EN && (to_cnt == TO_LAST)) begin
            wbm_cyc_o   <= 1'b0;
            wbm_stb_o   <= 1'b0;
            rsp_dat_o   <= '0;
            rsp_err_o   <= 1'b1;
            rsp_valid_o <= 1'b1;
            state       <= RESP;
          end else begin
            to_cnt <= to_cnt + CNT_W'(1);
          end
        end

        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            cmd_ready_o <= 1'b1;
            busy_o      <= 1'b0;
            state       <= IDLE;
          end
        end

        default: begin
          state       <= IDLE;
          wbm_cyc_o   <= 1'b0;
          wbm_stb_o   <= 1'b0;
          rsp_valid_o <= 1'b0;
          cmd_ready_o <= 1'b0;
          busy_o      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Self-checking bench for wb_cmd_master: directed table, random transactions
// against a transaction-level model, and reset/spurious-ack sequences.
module tb_wb_cmd_master;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic        cmd_we_i = 1'b0;
  logic [31:0] cmd_adr_i = '0;
  logic [31:0] cmd_dat_i = '0;
  logic [3:0]  cmd_sel_i = '0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic [31:0] rsp_dat_o;
  logic        rsp_err_o;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic        wbm_ack_i = 1'b0;
  logic [31:0] wbm_dat_i = '0;
  logic        busy_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_cmd_master #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(T), .CNT_W(8)
  ) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_adr_i(cmd_adr_i), .cmd_dat_i(cmd_dat_i), .cmd_sel_i(cmd_sel_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_dat_o(rsp_dat_o), .rsp_err_o(rsp_err_o),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
    .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i), .busy_o(busy_o)
  );

  typedef struct {
    bit          we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          waits;      // slave wait states before ack
    logic [31:0] rdat;
    int          rsp_delay;  // cycles of response backpressure
    bit          exp_err;
    logic [31:0] exp_dat;
    int          exp_stb;    // cycles stb is seen high
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level expectation: slave acks after `waits` wait states unless the timeout comes first.
  task automatic model(input bit we, input int waits, input logic [31:0] rdat,
                       output bit err, output logic [31:0] d, output int stbc);
    if (waits < T) begin
      err = 1'b0; d = we ? 32'h0 : rdat; stbc = waits + 1;
    end else begin
      err = 1'b1; d = 32'h0; stbc = T;
    end
  endtask

  task automatic rand_cmd(input bit force_valid);
    cmd_valid_i = force_valid ? 1'b1 : 1'($urandom);
    cmd_we_i    = 1'($urandom);
    cmd_adr_i   = $urandom;
    cmd_dat_i   = $urandom;
    cmd_sel_i   = 4'($urandom);
  endtask

  task automatic run_txn(input vec_t v);
    int  n;
    int  stbc;
    bit  done;
    @(negedge clk);
    n = 0;
    while (!cmd_ready_o && n < 20) begin @(negedge clk); n++; end
    chk("cmd_ready_before", 32'(cmd_ready_o), 32'd1);
    cmd_valid_i = 1'b1; cmd_we_i = v.we; cmd_adr_i = v.adr;
    cmd_dat_i = v.dat; cmd_sel_i = v.sel;
    @(negedge clk);
    stbc = 0; done = 0; n = 0;
    while (!done) begin
      if (wbm_stb_o && n < 40) begin
        stbc++;
        chk("bus_cyc", 32'(wbm_cyc_o), 32'd1);
        chk("bus_we", 32'(wbm_we_o), 32'(v.we));
        chk("bus_adr", wbm_adr_o, v.adr);
        chk("bus_dat", wbm_dat_o, v.dat);
        chk("bus_sel", 32'(wbm_sel_o), 32'(v.sel));
        chk("bus_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("bus_cmd_ready", 32'(cmd_ready_o), 32'd0);
        chk("bus_busy", 32'(busy_o), 32'd1);
        wbm_ack_i = (stbc == v.waits + 1);
        wbm_dat_i = wbm_ack_i ? v.rdat : $urandom;
        rand_cmd(1'b0);
        @(negedge clk);
        n++;
      end else begin
        done = 1;
      end
    end
    wbm_ack_i = 1'b0;
    chk("stb_cycles", 32'(stbc), 32'(v.exp_stb));
    chk("end_cyc", 32'(wbm_cyc_o), 32'd0);
    chk("end_we_held", 32'(wbm_we_o), 32'(v.we));
    chk("end_adr_held", wbm_adr_o, v.adr);
    chk("rsp_valid", 32'(rsp_valid_o), 32'd1);
    chk("rsp_err", 32'(rsp_err_o), 32'(v.exp_err));
    chk("rsp_dat", rsp_dat_o, v.exp_dat);
    chk("rsp_busy", 32'(busy_o), 32'd1);
    for (int i = 0; i < v.rsp_delay; i++) begin
      rand_cmd(1'b1);
      wbm_ack_i = 1'($urandom);
      @(negedge clk);
      chk("bp_rsp_valid", 32'(rsp_valid_o), 32'd1);
      chk("bp_rsp_err", 32'(rsp_err_o), 32'(v.exp_err));
      chk("bp_rsp_dat", rsp_dat_o, v.exp_dat);
      chk("bp_cyc", 32'(wbm_cyc_o), 32'd0);
      chk("bp_cmd_ready", 32'(cmd_ready_o), 32'd0);
    end
    wbm_ack_i = 1'b0;
    rsp_ready_i = 1'b1; cmd_valid_i = 1'b0;
    @(negedge clk);
    rsp_ready_i = 1'b0;
    chk("done_rsp_valid", 32'(rsp_valid_o), 32'd0);
    chk("done_cmd_ready", 32'(cmd_ready_o), 32'd1);
    chk("done_busy", 32'(busy_o), 32'd0);
  endtask

  vec_t tbl [6];

  initial begin
    vec_t r;
    tbl[0] = '{1'b1, 32'h3000_0004, 32'hA5A5_1234, 4'hF, 2,  32'h1111_2222, 1,  1'b0, 32'h0,         3};
    tbl[1] = '{1'b0, 32'h3000_0000, 32'h0000_0000, 4'hF, 0,  32'hDEAD_0001, 0,  1'b0, 32'hDEAD_0001, 1};
    tbl[2] = '{1'b0, 32'h3000_0008, 32'h5555_AAAA, 4'hF, 99, 32'hBAD0_BAD0, 2,  1'b1, 32'h0,         4};
    tbl[3] = '{1'b0, 32'h3000_000C, 32'h0,         4'hF, 3,  32'h1234_5678, 0,  1'b0, 32'h1234_5678, 4};
    tbl[4] = '{1'b0, 32'h3000_0010, 32'h0,         4'h1, 1,  32'hCAFE_F00D, 10, 1'b0, 32'hCAFE_F00D, 2};
    tbl[5] = '{1'b1, 32'h3000_0014, 32'h0BAD_BEEF, 4'h3, 0,  32'hFFFF_FFFF, 0,  1'b0, 32'h0,         1};

    // Reset values, and cmd_ready only after the first edge following release.
    #12;
    chk("rst_cyc", 32'(wbm_cyc_o), 32'd0);
    chk("rst_stb", 32'(wbm_stb_o), 32'd0);
    chk("rst_adr", wbm_adr_o, 32'd0);
    chk("rst_dat_o", wbm_dat_o, 32'd0);
    chk("rst_sel", 32'(wbm_sel_o), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    chk("rst_rsp_dat", rsp_dat_o, 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    #2 chk("rel_cmd_ready_pre", 32'(cmd_ready_o), 32'd0);
    @(negedge clk);
    chk("rel_cmd_ready_post", 32'(cmd_ready_o), 32'd1);

    for (int i = 0; i < 6; i++) run_txn(tbl[i]);

    for (int i = 0; i < 30; i++) begin
      r.we = 1'($urandom); r.adr = $urandom; r.dat = $urandom; r.sel = 4'($urandom);
      r.waits = int'($urandom_range(0, 6)); r.rdat = $urandom;
      r.rsp_delay = int'($urandom_range(0, 3));
      model(r.we, r.waits, r.rdat, r.exp_err, r.exp_dat, r.exp_stb);
      run_txn(r);
    end

    // Async reset in the middle of a bus cycle, then a spurious ack while idle.
    @(negedge clk);
    cmd_valid_i = 1'b1; cmd_we_i = 1'b0; cmd_adr_i = 32'h3000_0020; cmd_sel_i = 4'hF;
    @(negedge clk);
    cmd_valid_i = 1'b0;
    chk("mid_stb", 32'(wbm_stb_o), 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cyc", 32'(wbm_cyc_o), 32'd0);
    chk("arst_stb", 32'(wbm_stb_o), 32'd0);
    chk("arst_busy", 32'(busy_o), 32'd0);
    chk("arst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_no_rsp", 32'(rsp_valid_o), 32'd0);
    chk("arst_cmd_ready", 32'(cmd_ready_o), 32'd1);
    wbm_ack_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("spur_busy", 32'(busy_o), 32'd0);
      chk("spur_cyc", 32'(wbm_cyc_o), 32'd0);
      chk("spur_rsp_valid", 32'(rsp_valid_o), 32'd0);
      chk("spur_cmd_ready", 32'(cmd_ready_o), 32'd1);
    end
    wbm_ack_i = 1'b0;
    run_txn(tbl[1]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
